// File: rtl/rr_flag_ctrl_bridge_if.sv
// Control/status bundle between the crossbar fan-in tree and its round-robin
// priority controller.
interface rr_flag_ctrl_bridge_if #(
  parameter int LOG_MASTER = 3,
  parameter int STALL_W    = 8
);
  logic                  en_i;
  logic                  req_root_i;
  logic                  gnt_root_i;
  logic                  lock_i;
  logic                  flag_load_i;
  logic [LOG_MASTER-1:0] flag_val_i;
  logic [LOG_MASTER-1:0] RR_FLAG_o;
  logic [STALL_W-1:0]    stall_cnt_o;
  logic                  stall_o;

  // Crossbar side: drives request/grant/control, observes flags and watchdog.
  modport master (
    output en_i, req_root_i, gnt_root_i, lock_i, flag_load_i, flag_val_i,
    input  RR_FLAG_o, stall_cnt_o, stall_o
  );

  // Controller side.
  modport slave (
    input  en_i, req_root_i, gnt_root_i, lock_i, flag_load_i, flag_val_i,
    output RR_FLAG_o, stall_cnt_o, stall_o
  );
endinterface

// File: rtl/rr_flag_ctrl_bridge.sv
// Round-robin priority pointer for the fan-in tree of the L2/TCDM bridge,
// with software reload, lock, and a starvation watchdog on the root request.
module rr_flag_ctrl_bridge #(
  parameter int N_MASTER   = 8,
  parameter int LOG_MASTER = $clog2(N_MASTER),
  parameter int MODE       = 0,
  parameter int STALL_W    = 8,
  parameter int STALL_MAX  = 64
) (
  input logic                 clk,
  input logic                 rst,
  rr_flag_ctrl_bridge_if.slave ctrl
);

  localparam logic [LOG_MASTER-1:0] PTR_LAST  = LOG_MASTER'(N_MASTER - 1);
  localparam logic [STALL_W-1:0]    SC_SAT    = '1;
  localparam logic [STALL_W-1:0]    STALL_THR = STALL_W'(STALL_MAX);

  logic                  hs;
  logic                  adv;
  logic [LOG_MASTER-1:0] ptr_q, ptr_d;
  logic [STALL_W-1:0]    sc_q, sc_d;
  logic                  stall_q, stall_d;

  always_comb begin
    hs = ctrl.req_root_i & ctrl.gnt_root_i;
    // Time-slice mode rotates while the root is requesting, granted or not.
    if (MODE == 1) adv = ctrl.en_i & ~ctrl.lock_i & ctrl.req_root_i;
    else           adv = ctrl.en_i & ~ctrl.lock_i & hs;
  end

  // Load wins over advance and lock; an accompanying handshake is dropped.
  always_comb begin
    ptr_d = ptr_q;
    if (ctrl.flag_load_i) begin
      ptr_d = ctrl.flag_val_i;
    end else if (adv) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + LOG_MASTER'(1);
    end
  end

  // Alarm is judged on the updated count so it rises with the count itself.
  always_comb begin
    sc_d = sc_q;
    if (!ctrl.req_root_i || hs) begin
      sc_d = '0;
    end else if (sc_q != SC_SAT) begin
      sc_d = sc_q + STALL_W'(1);
    end
    stall_d = (sc_d >= STALL_THR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      sc_q    <= '0;
      stall_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      sc_q    <= sc_d;
      stall_q <= stall_d;
    end
  end

  assign ctrl.RR_FLAG_o   = ptr_q;
  assign ctrl.stall_cnt_o = sc_q;
  assign ctrl.stall_o     = stall_q;

endmodule

// File: tb/tb_rr_flag_ctrl_bridge.sv
// Directed bench for rr_flag_ctrl_bridge: MODE 0, MODE 1 and a narrow
// watchdog instance share clock and reset.
module tb_rr_flag_ctrl_bridge;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  rr_flag_ctrl_bridge_if #(.LOG_MASTER(3), .STALL_W(8)) if0 ();
  rr_flag_ctrl_bridge_if #(.LOG_MASTER(3), .STALL_W(8)) if1 ();
  rr_flag_ctrl_bridge_if #(.LOG_MASTER(3), .STALL_W(3)) if2 ();

  rr_flag_ctrl_bridge #(.N_MASTER(8), .MODE(0), .STALL_W(8), .STALL_MAX(4))
    u0 (.clk(clk), .rst(rst), .ctrl(if0));
  rr_flag_ctrl_bridge #(.N_MASTER(8), .MODE(1), .STALL_W(8), .STALL_MAX(4))
    u1 (.clk(clk), .rst(rst), .ctrl(if1));
  rr_flag_ctrl_bridge #(.N_MASTER(8), .MODE(0), .STALL_W(3), .STALL_MAX(4))
    u2 (.clk(clk), .rst(rst), .ctrl(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic en, input logic req, input logic gnt, input logic lock,
                      input logic load, input logic [2:0] val);
    if0.en_i = en; if0.req_root_i = req; if0.gnt_root_i = gnt;
    if0.lock_i = lock; if0.flag_load_i = load; if0.flag_val_i = val;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drv0(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    if1.en_i = 1'b1; if1.req_root_i = 1'b0; if1.gnt_root_i = 1'b0;
    if1.lock_i = 1'b0; if1.flag_load_i = 1'b0; if1.flag_val_i = 3'd0;
    if2.en_i = 1'b1; if2.req_root_i = 1'b0; if2.gnt_root_i = 1'b0;
    if2.lock_i = 1'b0; if2.flag_load_i = 1'b0; if2.flag_val_i = 3'd0;

    #12;
    chk("reset_flag", 32'(if0.RR_FLAG_o), 0);
    chk("reset_cnt", 32'(if0.stall_cnt_o), 0);
    chk("reset_stall", 32'(if0.stall_o), 0);
    rst = 1'b0;
    tick();
    chk("idle_flag", 32'(if0.RR_FLAG_o), 0);

    // Ten back-to-back handshakes: 1..7, wrap to 0, then 1, 2.
    drv0(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("adv_%0d", i), 32'(if0.RR_FLAG_o), i % 8);
      chk($sformatf("adv_cnt_%0d", i), 32'(if0.stall_cnt_o), 0);
    end
    tick();
    chk("adv_to_3", 32'(if0.RR_FLAG_o), 3);

    drv0(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("lock_hold_%0d", i), 32'(if0.RR_FLAG_o), 3);
    end
    drv0(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("en_hold_%0d", i), 32'(if0.RR_FLAG_o), 3);
    end
    drv0(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    chk("release_adv", 32'(if0.RR_FLAG_o), 4);
    tick();
    chk("adv_to_5", 32'(if0.RR_FLAG_o), 5);

    // Load + handshake + lock in one cycle: load wins, no increment.
    drv0(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2);
    tick();
    chk("load_collision", 32'(if0.RR_FLAG_o), 2);
    drv0(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    chk("load_hold", 32'(if0.RR_FLAG_o), 2);

    // Watchdog: request without grant.
    drv0(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("wd_cnt_%0d", k), 32'(if0.stall_cnt_o), k);
      chk($sformatf("wd_stall_%0d", k), 32'(if0.stall_o), (k >= 4) ? 1 : 0);
    end
    chk("wd_flag_hold", 32'(if0.RR_FLAG_o), 2);
    drv0(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    chk("wd_clr_cnt", 32'(if0.stall_cnt_o), 0);
    chk("wd_clr_stall", 32'(if0.stall_o), 0);
    chk("wd_clr_flag", 32'(if0.RR_FLAG_o), 3);

    // MODE 1 time-slice.
    if1.req_root_i = 1'b1; if1.gnt_root_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("ts_flag_%0d", k), 32'(if1.RR_FLAG_o), k);
    end
    if1.req_root_i = 1'b0;
    tick();
    chk("ts_hold_a", 32'(if1.RR_FLAG_o), 3);
    tick();
    chk("ts_hold_b", 32'(if1.RR_FLAG_o), 3);

    // Saturation on the 3-bit watchdog.
    if2.req_root_i = 1'b1; if2.gnt_root_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("sat_cnt_%0d", k), 32'(if2.stall_cnt_o), (k > 7) ? 7 : k);
      chk($sformatf("sat_stall_%0d", k), 32'(if2.stall_o), (k >= 4) ? 1 : 0);
    end
    chk("sat_flag_hold", 32'(if2.RR_FLAG_o), 0);

    // Async reset mid-cycle with ptr=6 and sc=3.
    drv0(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6);
    tick();
    drv0(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    for (int k = 0; k < 3; k++) tick();
    chk("pre_rst_flag", 32'(if0.RR_FLAG_o), 6);
    chk("pre_rst_cnt", 32'(if0.stall_cnt_o), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_flag", 32'(if0.RR_FLAG_o), 0);
    chk("arst_cnt", 32'(if0.stall_cnt_o), 0);
    chk("arst_stall", 32'(if0.stall_o), 0);
    chk("arst_flag_u1", 32'(if1.RR_FLAG_o), 0);
    chk("arst_cnt_u2", 32'(if2.stall_cnt_o), 0);
    chk("arst_stall_u2", 32'(if2.stall_o), 0);
    tick();
    chk("arst_held_flag", 32'(if0.RR_FLAG_o), 0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rr_flag_ctrl_bridge.md
# rr_flag_ctrl_bridge

Round-robin priority controller for a binary tree of two-input request fan-in stages in the L2/TCDM bridge crossbar. It owns the per-level `RR_FLAG` bits that each fan-in stage uses to choose between its two channels. The flags advance only on accepted transfers at the tree root, so every requester eventually wins. It also supports software reload of the priority pointer, a lock for atomic multi-word sequences, and a starvation watchdog.

## Interface
- `N_MASTER`, default 8: number of tree leaves; must be a power of two, ≥2.
- `LOG_MASTER`, default $clog2(N_MASTER): flag vector width, equal to the number of tree levels.
- `MODE`, default 0: 0 = advance on every root handshake; 1 = advance on every cycle the root request is high (time-slice).
- `STALL_W`, default 8: width of the watchdog counter.
- `STALL_MAX`, default 64: watchdog threshold; must be ≤ 2^STALL_W−1.
- `clk`, in, 1: clock. Single clock domain.
- `rst`, in, 1: asynchronous, active-high reset.
- `en_i`, in, 1: advance enable. When low, flags are frozen; load still works.
- `req_root_i`, in, 1: request output of the root fan-in stage.
- `gnt_root_i`, in, 1: grant into the root fan-in stage.
- `lock_i`, in, 1: hold the current priority (atomic sequence in progress).
- `flag_load_i`, in, 1: load the priority pointer from `flag_val_i`.
- `flag_val_i`, in, LOG_MASTER: value to load.
- `RR_FLAG_o`, out, LOG_MASTER: bit k drives every fan-in stage at tree level k. Level 0 is the leaf level; level LOG_MASTER−1 is the root.
- `stall_cnt_o`, out, STALL_W: current watchdog count.
- `stall_o`, out, 1: starvation alarm.

## Operation
- The priority pointer `ptr` is a LOG_MASTER-bit register, and `RR_FLAG_o = ptr` directly, with no combinational path from inputs.
- Handshake: `hs = req_root_i & gnt_root_i`.
- Advance condition:
  - MODE 0: `adv = en_i & ~lock_i & hs`.
  - MODE 1: `adv = en_i & ~lock_i & req_root_i`.
- Next-pointer priority, highest first:
  1. `flag_load_i` → `ptr <= flag_val_i`.
  2. `adv` → `ptr <= ptr + 1`, modulo N_MASTER; N_MASTER−1 wraps to 0.
  3. Otherwise hold.
- Load overrides advance and lock in the same cycle; the handshake in that cycle does not increment.
- Because `ptr` is a binary counter, leaf flags toggle on every advance and root flags toggle every N_MASTER/2 advances.
- Watchdog counter `sc`, next-value priority highest first:
  1. `~req_root_i | hs` → clear to 0.
  2. `req_root_i & ~gnt_root_i` → increment, saturating at 2^STALL_W−1.
- `stall_o` is registered and equals `sc >= STALL_MAX`, evaluated on the updated count. It is therefore high in the same cycle that `stall_cnt_o` first shows STALL_MAX.
- Lock and `en_i` do not affect the watchdog.
- `stall_o` is a status output only; it does not alter arbitration.

## Timing
- Reset values: `ptr = 0`, `RR_FLAG_o = 0`, `sc = 0`, `stall_cnt_o = 0`, `stall_o = 0`.
- Reset mid-operation forces all of these asynchronously, regardless of lock or load.
- Latency: a handshake in cycle t changes `RR_FLAG_o` at t+1. The fan-in stages therefore arbitrate on the pre-advance flags in cycle t, and the granted channel loses priority from t+1.
- A load in cycle t is visible at t+1.
- Back-to-back handshakes advance once per cycle.
- Lock asserted in cycle t blocks the advance for a handshake in cycle t.
- Watchdog: with `req_root_i` held high and `gnt_root_i` held low from cycle 0, `stall_cnt_o = n` after n edges and `stall_o` rises after STALL_MAX edges.

## Test plan
All scenarios use N_MASTER=8 and STALL_MAX=4 unless noted.
- Reset then advance: assert and release `rst`; drive 10 consecutive handshakes in MODE 0 → `RR_FLAG_o` reads 0,1,…,7,0,1,2 cycle by cycle, each step one cycle after its handshake (wrap 7→0 checked).
- Lock and enable: with `ptr=3`, drive 5 handshakes with `lock_i=1`, then 5 with `en_i=0` → `RR_FLAG_o` stays 3; one further handshake with both released → 4.
- Load collision: with `ptr=5`, in one cycle assert `flag_load_i`, `flag_val_i=2`, a handshake and `lock_i=1` → next `RR_FLAG_o=2`; no increment to 3.
- MODE 1 time-slice: hold `req_root_i=1`, `gnt_root_i=0` for 3 cycles → flags 1,2,3; drop the request → flags hold.
- Watchdog: hold the request with no grant for 6 cycles → `stall_cnt_o` 1..6, `stall_o` high from count 4; one handshake → count 0, `stall_o` 0 next cycle.
- Watchdog saturation: with STALL_W=3, hold the request with no grant for 12 cycles → count saturates at 7.
- Asynchronous reset mid-stream: assert `rst` between clock edges with `ptr=6` and `sc=3` → all outputs 0 immediately.
